// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment driver: per-frame snapshot of the
// segment bytes, dead time at each slot start, per-digit blink and blanking.
module seven_seg_scanner #(
   parameter int SCAN_DIV  = 100000,
   parameter int DEAD_CYC  = 1000,
   parameter int BLINK_DIV = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] board7SD,
   input  logic        blank,
   input  logic [3:0]  blinkMask,
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic        frameStart
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEAD_LIM = CW'(DEAD_CYC);
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    dig;
   logic [FW-1:0] frm;
   logic          ph;
   logic [31:0]   snap;
   logic [3:0]    anNext;
   logic [7:0]    segNext;
   logic [7:0]    curByte;

   assign curByte = snap[{dig, 3'b000} +: 8];

   // Anode drive is at most one-hot low by construction: a single shifted bit or all-off.
   always_comb begin
      segNext = ~curByte;
      anNext  = ~(4'b0001 << dig);
      if ((cnt < DEAD_LIM) || (ph && blinkMask[dig])) anNext = '1;
      if (blank) begin
         anNext  = '1;
         segNext = '1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         dig        <= '0;
         frm        <= '0;
         ph         <= 1'b0;
         snap       <= '0;
         an         <= '1;
         seg        <= '1;
         frameStart <= 1'b0;
      end else begin
         frameStart <= 1'b0;
         an         <= anNext;
         seg        <= segNext;
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            dig <= dig + 2'd1;
            if (dig == 2'd3) begin
               snap       <= board7SD;
               frameStart <= 1'b1;
               if (frm == FRM_LAST) begin
                  frm <= '0;
                  ph  <= ~ph;
               end else begin
                  frm <= frm + 1'b1;
               end
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner against a cycle-count based model.
module tb_seven_seg_scanner;

   localparam int S = 4;
   localparam int D = 1;
   localparam int B = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] board7SD = '0;
   logic        blank = 1'b0;
   logic [3:0]  blinkMask = '0;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        frameStart;

   int unsigned total = 0;
   int unsigned bad = 0;

   // model: everything derived from the number of edges since reset release
   int unsigned mN = 0;
   logic [31:0] mSnap = '0;
   logic [3:0]  expAn;
   logic [7:0]  expSeg;
   logic        expFs;

   seven_seg_scanner #(.SCAN_DIV(S), .DEAD_CYC(D), .BLINK_DIV(B)) dut (
      .clk(clk), .rst(rst), .board7SD(board7SD), .blank(blank),
      .blinkMask(blinkMask), .an(an), .seg(seg), .frameStart(frameStart)
   );

   always #5 clk = ~clk;

   task automatic tick();
      int unsigned c, d, fr;
      @(posedge clk);
      c  = mN % S;
      d  = (mN / S) % 4;
      fr = mN / (4 * S);
      expSeg = blank ? 8'hFF : ~mSnap[d*8 +: 8];
      expAn  = 4'hF;
      if (!blank && c >= D && !(((fr / B) % 2 == 1) && blinkMask[d]))
         expAn = ~(4'b0001 << d);
      expFs = (c == S - 1) && (d == 3);
      if (expFs) mSnap = board7SD;
      mN++;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if ({an, seg, frameStart} !== {4'hF, 8'hFF, 1'b0}) begin
            bad++;
            $display("FAIL reset_hold i=%0d an got %b exp 1111 seg got %h exp ff fs got %b exp 0", i, an, seg, frameStart);
         end
      end
      board7SD = 32'h3F065B4F;
      rst = 1'b0;
      mN = 0;
      mSnap = '0;
   endtask

   task automatic test_frame();
      int unsigned firstFs = 0;
      logic [3:0] obsAn [1:40];
      logic [7:0] obsSeg [1:40];
      for (int i = 1; i <= 40; i++) begin
         tick();
         obsAn[i] = an;
         obsSeg[i] = seg;
         if (frameStart && firstFs == 0) firstFs = i;
         total++;
         if ({an, seg, frameStart} !== {expAn, expSeg, expFs}) begin
            bad++;
            $display("FAIL frame cyc=%0d an got %b exp %b seg got %h exp %h fs got %b exp %b", i, an, expAn, seg, expSeg, frameStart, expFs);
         end
      end
      total++;
      if (firstFs != 16) begin
         bad++;
         $display("FAIL first_framestart got %0d exp 16", firstFs);
      end
      total++;
      if (obsAn[17] !== 4'hF || obsAn[18] !== 4'b1110 || obsAn[20] !== 4'b1110 ||
          obsSeg[18] !== 8'hB0 || obsSeg[19] !== 8'hB0 || obsSeg[20] !== 8'hB0) begin
         bad++;
         $display("FAIL digit0_slot an got %b,%b,%b exp 1111,1110,1110 seg got %h,%h,%h exp b0,b0,b0",
                  obsAn[17], obsAn[18], obsAn[20], obsSeg[18], obsSeg[19], obsSeg[20]);
      end
      total++;
      if (obsAn[30] !== 4'b0111 || obsSeg[30] !== 8'hC0) begin
         bad++;
         $display("FAIL digit3_slot an got %b exp 0111 seg got %h exp c0", obsAn[30], obsSeg[30]);
      end
   endtask

   task automatic test_snapshot();
      int unsigned fsSeen = 0;
      int unsigned guard = 0;
      for (int i = 0; i < 6; i++) tick();
      board7SD = 32'h00000000;
      while (fsSeen < 2 && guard < 60) begin
         tick();
         guard++;
         if (frameStart) fsSeen++;
         total++;
         if ({an, seg, frameStart} !== {expAn, expSeg, expFs}) begin
            bad++;
            $display("FAIL snapshot cyc=%0d an got %b exp %b seg got %h exp %h fs got %b exp %b", guard, an, expAn, seg, expSeg, frameStart, expFs);
         end
      end
      total++;
      if (fsSeen < 2) begin
         bad++;
         $display("FAIL snapshot_timeout framestarts got %0d exp 2", fsSeen);
      end
   endtask

   task automatic test_blink();
      int unsigned dark0 = 0;
      board7SD = 32'h3F065B4F;
      blinkMask = 4'b0001;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (an === 4'b1110) dark0++;
         total++;
         if ({an, seg, frameStart} !== {expAn, expSeg, expFs}) begin
            bad++;
            $display("FAIL blink cyc=%0d an got %b exp %b seg got %h exp %h fs got %b exp %b", i, an, expAn, seg, expSeg, frameStart, expFs);
         end
      end
      blinkMask = 4'b0000;
      total++;
      if (dark0 == 0 || dark0 > 45) begin
         bad++;
         $display("FAIL blink_digit0_on_count got %0d exp between 1 and 45", dark0);
      end
   endtask

   task automatic test_blank();
      tick();
      tick();
      blank = 1'b1;
      for (int i = 0; i < 13; i++) begin
         if (i == 5) blank = 1'b0;
         tick();
         total++;
         if ({an, seg, frameStart} !== {expAn, expSeg, expFs}) begin
            bad++;
            $display("FAIL blank cyc=%0d an got %b exp %b seg got %h exp %h fs got %b exp %b", i, an, expAn, seg, expSeg, frameStart, expFs);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 240; i++) begin
         if ($urandom_range(0, 5) == 0) board7SD = $urandom;
         if ($urandom_range(0, 15) == 0) blinkMask = 4'($urandom);
         blank = ($urandom_range(0, 7) == 0);
         tick();
         total++;
         if ({an, seg, frameStart} !== {expAn, expSeg, expFs}) begin
            bad++;
            $display("FAIL random cyc=%0d an got %b exp %b seg got %h exp %h fs got %b exp %b", i, an, expAn, seg, expSeg, frameStart, expFs);
         end
         total++;
         if ($countones(~an) > 1) begin
            bad++;
            $display("FAIL onehot cyc=%0d an got %b exp at most one low", i, an);
         end
      end
      blank = 1'b0;
      blinkMask = 4'b0000;
   endtask

   task automatic test_rst_mid();
      int unsigned guard = 0;
      board7SD = 32'h3F065B4F;
      while (!((mN % (4 * S)) / S == 2 && (mN % S) == 3) && guard < 40) begin
         tick();
         guard++;
      end
      tick();
      total++;
      if (an !== expAn || guard >= 40) begin
         bad++;
         $display("FAIL rst_mid_setup an got %b exp %b guard=%0d", an, expAn, guard);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({an, seg, frameStart} !== {4'hF, 8'hFF, 1'b0}) begin
         bad++;
         $display("FAIL rst_async an got %b exp 1111 seg got %h exp ff fs got %b exp 0", an, seg, frameStart);
      end
      @(negedge clk);
      rst = 1'b0;
      mN = 0;
      mSnap = '0;
      for (int i = 0; i < 24; i++) begin
         tick();
         total++;
         if ({an, seg, frameStart} !== {expAn, expSeg, expFs}) begin
            bad++;
            $display("FAIL rst_restart cyc=%0d an got %b exp %b seg got %h exp %h fs got %b exp %b", i, an, expAn, seg, expSeg, frameStart, expFs);
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_snapshot();
      test_blink();
      test_blank();
      test_random();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
